phase_sequencer: RTL and testbench

Parametrised multi-phase trigger sequencer: a prescale counter divides enabled clock cycles into phase slots, and a phase index steps through N_PHASES one-hot trigger outputs. Successor to the fixed 3-phase/period-4 timer used by the LED shifter. Adds runtime period, four sequencing modes, direction state, wrap pulse and one-shot completion. Drives LED/segment multiplexers and other round-robin enables.

---
 rtl/phase_sequencer.sv | 93 +++++++++
 tb/tb_phase_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: prescaled multi-phase one-hot trigger sequencer
// with wrap-up, bounce, one-shot and wrap-down stepping modes.
module phase_sequencer #(
    parameter int N_PHASES = 3,
    parameter int CNT_WIDTH = 32,
    localparam int PHASE_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
    input  logic                 clk,
    input  logic                 async_reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] period_m1,
    input  logic [1:0]           mode,
    output logic [N_PHASES-1:0]  trigger,
    output logic [PHASE_W-1:0]   phase_idx,
    output logic                 wrap,
    output logic                 done
);
    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(N_PHASES - 1);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d, inc, dec;
    logic                 down_q, down_d, wrap_q, wrap_d, done_q, done_d, advance;
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
            down_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            down_q  <= down_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end
    // Index stepping wraps modulo N_PHASES, never 2^PHASE_W.
    always_comb begin
        inc     = (phase_q == LAST) ? '0 : phase_q + PHASE_W'(1);
        dec     = (phase_q == '0) ? LAST : phase_q - PHASE_W'(1);
        advance = enable && !done_q && (cnt_q >= period_m1);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        down_d  = down_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = '0;
            down_d  = 1'b0;
            done_d  = 1'b0;
        end else if (enable && !done_q) begin
            cnt_d = advance ? '0 : cnt_q + CNT_WIDTH'(1);
            if (advance) begin
                case (mode)
                    2'b00: begin
                        phase_d = inc;
                        wrap_d  = (phase_q == LAST);
                        down_d  = 1'b0;
                    end
                    2'b11: begin
                        phase_d = dec;
                        wrap_d  = (phase_q == '0);
                        down_d  = 1'b0;
                    end
                    2'b01: begin
                        if (N_PHASES == 1) begin
                            wrap_d = 1'b1;
                        end else if (!down_q) begin
                            down_d  = (phase_q == LAST);
                            phase_d = (phase_q == LAST) ? dec : inc;
                        end else begin
                            down_d  = (phase_q != '0);
                            phase_d = (phase_q == '0) ? inc : dec;
                            wrap_d  = (phase_q == '0);
                        end
                    end
                    default: begin
                        phase_d = inc;
                        done_d  = (inc == LAST);
                    end
                endcase
            end
        end
    end
    always_comb begin
        trigger   = N_PHASES'(1) << phase_q;
        phase_idx = phase_q;
        wrap      = wrap_q;
        done      = done_q;
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed checks of a 3-phase and a 4-phase sequencer
// driven by the same stimulus.
module tb_phase_sequencer;
    logic        clk = 1'b0, async_reset = 1'b1, clear = 1'b0, enable = 1'b0;
    logic [31:0] period_m1 = '0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  t3;
    logic [3:0]  t4;
    logic [1:0]  p3, p4;
    logic        w3, w4, d3, d4;
    int checks = 0, errors = 0;

    phase_sequencer #(.N_PHASES(3), .CNT_WIDTH(32)) u3 (
        .clk(clk), .async_reset(async_reset), .clear(clear), .enable(enable),
        .period_m1(period_m1), .mode(mode),
        .trigger(t3), .phase_idx(p3), .wrap(w3), .done(d3));
    phase_sequencer #(.N_PHASES(4), .CNT_WIDTH(32)) u4 (
        .clk(clk), .async_reset(async_reset), .clear(clear), .enable(enable),
        .period_m1(period_m1), .mode(mode),
        .trigger(t4), .phase_idx(p4), .wrap(w4), .done(d4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic st3(input string tag, input int ph, input bit w, input bit d);
        chk({tag, "_trg3"}, 64'(t3), 64'(1) << ph);
        chk({tag, "_ph3"}, 64'(p3), 64'(ph));
        chk({tag, "_wr3"}, 64'(w3), 64'(w));
        chk({tag, "_dn3"}, 64'(d3), 64'(d));
    endtask

    task automatic st4(input string tag, input int ph, input bit w, input bit d);
        chk({tag, "_trg4"}, 64'(t4), 64'(1) << ph);
        chk({tag, "_ph4"}, 64'(p4), 64'(ph));
        chk({tag, "_wr4"}, 64'(w4), 64'(w));
        chk({tag, "_dn4"}, 64'(d4), 64'(d));
    endtask

    initial begin
        int b4 [12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
        int b3 [12] = '{1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0};
        #12;
        st3("rst", 0, 0, 0);
        st4("rst", 0, 0, 0);
        @(posedge clk); #1;
        async_reset = 1'b0; mode = 2'b00; period_m1 = 3; enable = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            st3($sformatf("up%0d", k), (k / 4) % 3, (k % 12) == 0, 0);
        end
        // bounce, one step per enabled cycle
        clear = 1'b1; tick(1); clear = 1'b0;
        st3("bclr", 0, 0, 0);
        mode = 2'b01; period_m1 = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            st3($sformatf("bn%0d", k), b3[k-1], (k == 5) || (k == 9), 0);
            st4($sformatf("bn%0d", k), b4[k-1], k == 7, 0);
        end
        // one-shot freezes on final phase
        clear = 1'b1; tick(1); clear = 1'b0;
        mode = 2'b10; period_m1 = 1;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            st3($sformatf("os%0d", k), k < 2 ? 0 : k < 4 ? 1 : 2, 0, k >= 4);
        end
        st4("os", 3, 0, 1);
        mode = 2'b00; tick(3);
        st3("osfrz", 2, 0, 1);
        mode = 2'b10; clear = 1'b1; tick(1); clear = 1'b0;
        st3("osclr", 0, 0, 0);
        tick(2);
        st3("osres", 1, 0, 0);
        // wrap-down with an enable gap mid-slot
        clear = 1'b1; tick(1); clear = 1'b0;
        mode = 2'b11; period_m1 = 2;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            st3($sformatf("dn%0d", k), k < 3 ? 0 : k < 6 ? 2 : k < 9 ? 1 : 0, k == 3, 0);
        end
        enable = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            st3($sformatf("hold%0d", k), 0, 0, 0);
        end
        enable = 1'b1; tick(1);
        st3("dnext", 0, 0, 0);
        tick(1);
        st3("dnadv", 2, 1, 0);
        // period shrink mid-slot, then clear with enable
        clear = 1'b1; tick(1); clear = 1'b0;
        mode = 2'b00; period_m1 = 9; tick(6);
        st3("pr6", 0, 0, 0);
        period_m1 = 2; tick(1);
        st3("prshr", 1, 0, 0);
        clear = 1'b1; tick(1); clear = 1'b0;
        st3("clren", 0, 0, 0);
        tick(2);
        st3("clrc2", 0, 0, 0);
        tick(1);
        st3("clrc3", 1, 0, 0);
        // async reset between edges
        clear = 1'b1; tick(1); clear = 1'b0;
        mode = 2'b10; period_m1 = 0; tick(2);
        st3("pre", 2, 0, 1);
        #3 async_reset = 1'b1;
        #1;
        st3("arst", 0, 0, 0);
        st4("arst", 0, 0, 0);
        tick(1);
        st3("arsth", 0, 0, 0);
        async_reset = 1'b0; mode = 2'b00; period_m1 = 3;
        tick(3);
        st3("rel3", 0, 0, 0);
        tick(1);
        st3("rel4", 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
